// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array: accumulator format, drain FSM
// states and the sign-magnitude to two's-complement lane conversion.
package systolic_pkg;

  // Accumulator layout: 1 sign bit, 7 integer bits, 8 fraction bits.
  localparam int SIGN_W = 1;
  localparam int INT_W  = 7;
  localparam int FRAC_W = 8;
  localparam int DATA_W = SIGN_W + INT_W + FRAC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    FLUSH = 2'd3
  } drain_state_e;

  // Sign-magnitude to two's complement. Negative zero collapses to zero
  // because negating a zero magnitude yields zero.
  function automatic logic [DATA_W-1:0] sm_to_twos(input logic [DATA_W-1:0] sm);
    logic [DATA_W-1:0] mag;
    mag = {1'b0, sm[DATA_W-2:0]};
    return sm[DATA_W-1] ? ('0 - mag) : mag;
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO buffering drained columns (data plus last tag).
module drain_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage write.
  // NOTE: the data array has no reset; validity is tracked by count alone,
  // so clearing storage would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// Left-edge drain controller: shifts accumulators out of the array, buffers
// each column, streams column vectors on valid/ready, then clears the array.
module systolic_drain #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DATA_W   = systolic_pkg::DATA_W,
  parameter int DEPTH    = 2,
  parameter int TWOS_OUT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic [ROWS*DATA_W-1:0] col_in,
  output logic                   shift_out,
  output logic                   rst_output,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROWS*DATA_W-1:0] out_data,
  output logic                   out_last
);

  import systolic_pkg::*;

  localparam int VW    = ROWS * DATA_W;
  localparam int FW    = VW + 1;
  localparam int CNT_W = (COLS > 1) ? $clog2(COLS) : 1;

  drain_state_e     state;
  drain_state_e     state_next;
  logic [CNT_W-1:0] col;
  logic             push;
  logic             pop;
  logic             last_hs;
  logic             fifo_full;
  logic             fifo_empty;
  logic [VW-1:0]    conv;
  logic [FW-1:0]    fifo_dout;

  // Per-lane conversion applied on the way into the FIFO.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    if (TWOS_OUT != 0) begin : g_twos
      assign conv[r*DATA_W +: DATA_W] = sm_to_twos(col_in[r*DATA_W +: DATA_W]);
    end else begin : g_pass
      assign conv[r*DATA_W +: DATA_W] = col_in[r*DATA_W +: DATA_W];
    end
  end

  drain_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({(col == CNT_W'(COLS - 1)), conv}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The output side is just the FIFO head; data is forced to zero when empty
  // so nothing stale is presented.
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_dout[VW-1:0] : '0;
  assign out_last  = out_valid && fifo_dout[FW-1];
  assign pop       = out_valid && out_ready;
  assign last_hs   = pop && fifo_dout[FW-1];
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Column counter: restarts on an accepted start, advances on every push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        col <= '0;
    else if (state == IDLE && start)   col <= '0;
    else if (push)                     col <= col + CNT_W'(1);
  end

  // Next-state and control outputs. The last beat can complete while the
  // clear pulse is still out, so done is honoured in CLEAR as well as FLUSH.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    shift_out  = 1'b0;
    rst_output = 1'b0;
    push       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = DRAIN;
      end
      DRAIN: begin
        shift_out = !fifo_full;
        push      = !fifo_full;
        if (!fifo_full && col == CNT_W'(COLS - 1)) state_next = CLEAR;
      end
      CLEAR: begin
        rst_output = 1'b1;
        done       = last_hs;
        state_next = last_hs ? IDLE : FLUSH;
      end
      FLUSH: begin
        done = last_hs;
        if (last_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain: an array model feeds col_in, and
// every drain is checked against the columns loaded into that model.
module tb_systolic_drain;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int VW   = ROWS * DW;
  localparam int MAXK = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [VW-1:0] col_in;

  logic          busy, done, shift_out, rst_output, out_valid, out_last;
  logic [VW-1:0] out_data;
  logic          pt_busy, pt_done, pt_shift, pt_rst_output, pt_valid, pt_last;
  logic [VW-1:0] pt_data;

  logic [DW-1:0] acc        [ROWS][COLS];
  logic [DW-1:0] next_array [ROWS][COLS];
  logic          load_en = 1'b0;

  int checks = 0;
  int errors = 0;

  bit            shift_log [MAXK];
  bit            rst_log   [MAXK];
  bit            done_log  [MAXK];
  bit            busy_log  [MAXK];
  bit            valid_log [MAXK];
  logic [VW-1:0] got_data  [COLS];
  logic [VW-1:0] got_pt    [COLS];
  int            n_shift, n_rst, n_beats;

  always #5 clk = ~clk;

  systolic_drain #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .DEPTH(2), .TWOS_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .col_in(col_in), .shift_out(shift_out), .rst_output(rst_output),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  systolic_drain #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .DEPTH(2), .TWOS_OUT(0)) dut_pt (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(pt_busy), .done(pt_done),
    .col_in(col_in), .shift_out(pt_shift), .rst_output(pt_rst_output),
    .out_valid(pt_valid), .out_ready(out_ready), .out_data(pt_data),
    .out_last(pt_last)
  );

  // Array model: each row is a shift chain whose leftmost PE drives col_in.
  for (genvar r = 0; r < ROWS; r++) begin : g_col
    assign col_in[r*DW +: DW] = acc[r][0];
  end

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (load_en)         acc[r][c] <= next_array[r][c];
        else if (rst_output) acc[r][c] <= '0;
        else if (shift_out)  acc[r][c] <= (c == COLS - 1) ? '0 : acc[r][c+1];
      end
    end
  end

  // Expected lane value: magnitude negated when the sign bit is set.
  function automatic logic [DW-1:0] ref_conv(input logic [DW-1:0] v);
    int mag;
    int val;
    mag = int'(v[DW-2:0]);
    val = v[DW-1] ? -mag : mag;
    return val[DW-1:0];
  endfunction

  task automatic fill_random();
    logic [DW-1:0] corner [4];
    corner = '{16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF};
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        next_array[r][c] = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)]
                                                       : DW'($urandom);
  endtask

  // One drain of the array contents in next_array. Called and returns one
  // time unit after a rising edge. mode 0: ready high; 1: ready low through
  // cycle 'hold'; 2: random ready. repulse re-asserts start in cycle 2.
  // abort_k > 0 asserts rst_n in that cycle instead of finishing the drain.
  task automatic drain(input int mode, input int hold, input bit repulse, input int abort_k);
    logic [VW-1:0] exp_twos [COLS];
    logic [VW-1:0] exp_raw  [COLS];
    bit done_seen;
    bit finished;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        exp_raw[c][r*DW +: DW]  = next_array[r][c];
        exp_twos[c][r*DW +: DW] = ref_conv(next_array[r][c]);
      end
    for (int k = 0; k < MAXK; k++) begin
      shift_log[k] = 0; rst_log[k] = 0; done_log[k] = 0; busy_log[k] = 0; valid_log[k] = 0;
    end
    n_shift = 0; n_rst = 0; n_beats = 0;
    done_seen = 0; finished = 0;
    for (int k = 0; k < MAXK && !finished; k++) begin
      start   = (k == 0) || (repulse && k == 2);
      load_en = (k == 0);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k > hold);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_k > 0 && k == abort_k) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, shift_out, rst_output, out_valid, out_last, out_data} !== '0) begin
          errors++;
          $display("FAIL abort_outputs: busy=%b done=%b shift=%b rst_out=%b valid=%b last=%b data=%h, expected all zero",
                   busy, done, shift_out, rst_output, out_valid, out_last, out_data);
        end
        checks++;
        if (n_shift != 2) begin
          errors++;
          $display("FAIL abort_shifts: got %0d shifts before reset, expected 2", n_shift);
        end
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          checks++;
          if (rst_output !== 1'b0 || shift_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_clear: rst_output=%b shift_out=%b during reset, expected 0 0",
                     rst_output, shift_out);
          end
          @(posedge clk); #1;
        end
        rst_n = 1'b1;
        finished = 1;
      end else begin
        @(negedge clk);
        shift_log[k] = shift_out;
        rst_log[k]   = rst_output;
        done_log[k]  = done;
        busy_log[k]  = busy;
        valid_log[k] = out_valid;
        if (shift_out === 1'b1) n_shift++;
        if (rst_output === 1'b1) n_rst++;
        if (k == 0) begin
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_at_start: busy=%b, expected 0", busy);
          end
        end
        checks++;
        if ((shift_out & rst_output) !== 1'b0) begin
          errors++;
          $display("FAIL shift_clear_overlap: cycle %0d shift_out=%b rst_output=%b", k, shift_out, rst_output);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          if (n_beats >= COLS) begin
            errors++;
            $display("FAIL extra_beat: beat %0d seen, expected only %0d", n_beats, COLS);
          end else begin
            got_data[n_beats] = out_data;
            got_pt[n_beats]   = pt_data;
            if (out_data !== exp_twos[n_beats] || out_last !== (n_beats == COLS - 1)) begin
              errors++;
              $display("FAIL beat_data: beat %0d data=%h last=%b, expected %h last=%b",
                       n_beats, out_data, out_last, exp_twos[n_beats], (n_beats == COLS - 1));
            end
            checks++;
            if (pt_data !== exp_raw[n_beats] || pt_last !== (n_beats == COLS - 1)) begin
              errors++;
              $display("FAIL passthru_data: beat %0d data=%h last=%b, expected %h last=%b",
                       n_beats, pt_data, pt_last, exp_raw[n_beats], (n_beats == COLS - 1));
            end
          end
          n_beats++;
        end
        if (done === 1'b1) begin
          checks++;
          if (!(out_valid === 1'b1 && out_ready === 1'b1 && out_last === 1'b1)) begin
            errors++;
            $display("FAIL done_on_last: done without last handshake (valid=%b ready=%b last=%b)",
                     out_valid, out_ready, out_last);
          end
          done_seen = 1;
          finished  = 1;
        end
        @(posedge clk); #1;
      end
    end
    start   = 1'b0;
    load_en = 1'b0;
    if (abort_k == 0) begin
      checks++;
      if (!done_seen) begin
        errors++;
        $display("FAIL drain_timeout: no done within %0d cycles", MAXK);
      end
      checks++;
      if (n_beats != COLS) begin
        errors++;
        $display("FAIL beat_count: got %0d beats, expected %0d", n_beats, COLS);
      end
      checks++;
      if (n_rst != 1) begin
        errors++;
        $display("FAIL clear_count: got %0d rst_output cycles, expected 1", n_rst);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, shift_out, rst_output, out_valid, out_last, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b shift=%b rst_out=%b valid=%b last=%b data=%h, expected all zero",
               busy, done, shift_out, rst_output, out_valid, out_last, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] row0_in   [COLS];
    logic [DW-1:0] row0_want [COLS];
    row0_in   = '{16'h0100, 16'h8100, 16'h0280, 16'h8000};
    row0_want = '{16'h0100, 16'hFF00, 16'h0280, 16'h0000};
    fill_random();
    for (int c = 0; c < COLS; c++) next_array[0][c] = row0_in[c];
    drain(0, 0, 0, 0);
    for (int c = 0; c < COLS; c++) begin
      checks++;
      if (got_data[c][DW-1:0] !== row0_want[c]) begin
        errors++;
        $display("FAIL basic_row0: beat %0d lane0=%h, expected %h", c, got_data[c][DW-1:0], row0_want[c]);
      end
    end
    for (int k = 0; k <= 5; k++) begin
      checks++;
      if (shift_log[k] !== (k >= 1 && k <= 4)) begin
        errors++;
        $display("FAIL basic_shift_timing: cycle %0d shift_out=%b, expected %b", k, shift_log[k], (k >= 1 && k <= 4));
      end
    end
    checks++;
    if (rst_log[5] !== 1'b1 || done_log[5] !== 1'b1) begin
      errors++;
      $display("FAIL basic_clear_done: cycle 5 rst_output=%b done=%b, expected 1 1", rst_log[5], done_log[5]);
    end
    checks++;
    if (busy_log[1] !== 1'b1 || valid_log[1] !== 1'b0 || valid_log[2] !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: busy@1=%b valid@1=%b valid@2=%b, expected 1 0 1",
               busy_log[1], valid_log[1], valid_log[2]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_drop: busy=%b in cycle 6, expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int window;
    fill_random();
    drain(1, 6, 0, 0);
    window = 0;
    for (int k = 1; k <= 6; k++) window += int'(shift_log[k]);
    checks++;
    if (window != 2 || shift_log[1] !== 1'b1 || shift_log[2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_shifts: %0d shifts in cycles 1..6 (s1=%b s2=%b), expected 2 in cycles 1,2",
               window, shift_log[1], shift_log[2]);
    end
    checks++;
    if (valid_log[6] !== 1'b1 || shift_log[6] !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: cycle 6 valid=%b shift=%b, expected 1 0", valid_log[6], shift_log[6]);
    end
  endtask

  task automatic test_repulse();
    fill_random();
    drain(0, 0, 1, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || shift_out !== 1'b0) begin
        errors++;
        $display("FAIL repulse_idle: busy=%b shift_out=%b after done, expected 0 0", busy, shift_out);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_passthrough();
    fill_random();
    next_array[0][0] = 16'h8100;
    next_array[0][1] = 16'h7FFF;
    drain(0, 0, 0, 0);
    checks++;
    if (got_pt[0][DW-1:0] !== 16'h8100 || got_pt[1][DW-1:0] !== 16'h7FFF) begin
      errors++;
      $display("FAIL passthru_lanes: got %h %h, expected 8100 7fff", got_pt[0][DW-1:0], got_pt[1][DW-1:0]);
    end
  endtask

  task automatic test_abort();
    fill_random();
    drain(0, 0, 0, 3);
    fill_random();
    drain(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      fill_random();
      drain(2, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_repulse();
    test_passthrough();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
